pio_edge_master: RTL and testbench

PIO_EDGE_MASTER -- requirements
Module: pio_edge_master

---
 rtl/pio_edge_master_pkg.sv | 26 ++
 rtl/pio_edge_master_if.sv | 32 +++
 rtl/pio_edge_master.sv | 137 +++++++++++++
 tb/tb_pio_edge_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_edge_master_pkg.sv
// Shared types and constants for the edge-capture PIO interrupt servicing master.
package pio_edge_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MASK,
    RD_CAP,
    WAIT_CAP,
    WR_CLR,
    RD_DATA,
    WAIT_DATA,
    PUSH
  } stateT;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int         AVM_DW   = 32;
  localparam logic [7:0] SPUR_MAX = 8'hFF;

  function automatic logic [7:0] satInc(input logic [7:0] value);
    return (value == SPUR_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pio_edge_master_if.sv
// Avalon-MM master command bus plus the valid/ready event stream of the PIO servicing block.
interface pio_edge_master_if #(
  parameter int DATA_W = 10
);

  logic [1:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_edges;
  logic [DATA_W-1:0] evt_level;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, avm_waitrequest,
    output evt_valid, evt_edges, evt_level,
    input  evt_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, avm_waitrequest,
    input  evt_valid, evt_edges, evt_level,
    output evt_ready
  );

endinterface

// File: rtl/pio_edge_master.sv
// Services an edge-capture PIO: keeps its irq mask in sync, reads and clears the
// capture register, samples the data register and emits one event per real interrupt.
module pio_edge_master
  import pio_edge_master_pkg::*;
#(
  parameter int DATA_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq,
  input  logic              cfg_enable,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic [7:0]        spurious_cnt,
  pio_edge_master_if.master bus
);

  localparam int                CNT_W    = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(READ_LATENCY);

  stateT             state_q, state_d;
  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] maskPend_q;
  logic [DATA_W-1:0] edges_q;
  logic [DATA_W-1:0] level_q;
  logic [7:0]        spur_q;
  logic [CNT_W-1:0]  latCnt_q;

  logic              cmdAccept;
  logic              readAccept;
  logic              inWait;
  logic              latDone;
  logic [DATA_W-1:0] rdBits;
  logic              rdZero;

  assign cmdAccept  = (state_q == WR_MASK || state_q == RD_CAP ||
                       state_q == WR_CLR  || state_q == RD_DATA) && !bus.avm_waitrequest;
  assign readAccept = (state_q == RD_CAP || state_q == RD_DATA) && !bus.avm_waitrequest;
  assign inWait     = (state_q == WAIT_CAP || state_q == WAIT_DATA);
  assign latDone    = inWait && (latCnt_q == LAT_LAST);
  assign rdBits     = bus.avm_readdata[DATA_W-1:0];
  assign rdZero     = (rdBits == '0);

  if (DATA_W < AVM_DW) begin : gUnusedRd
    logic unusedRdBits;
    assign unusedRdBits = ^bus.avm_readdata[AVM_DW-1:DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A pending mask change always wins over a new service so the slave never fires on a stale mask.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_mask != shadow_q)     state_d = WR_MASK;
        else if (cfg_enable && irq)   state_d = RD_CAP;
      end
      WR_MASK:   if (cmdAccept)       state_d = IDLE;
      RD_CAP:    if (cmdAccept)       state_d = WAIT_CAP;
      WAIT_CAP:  if (latDone)         state_d = rdZero ? IDLE : WR_CLR;
      WR_CLR:    if (cmdAccept)       state_d = RD_DATA;
      RD_DATA:   if (cmdAccept)       state_d = WAIT_DATA;
      WAIT_DATA: if (latDone)         state_d = PUSH;
      PUSH:      if (bus.evt_ready)   state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // The mask is latched on entry to WR_MASK so writedata cannot move under a stalled write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q   <= '0;
      maskPend_q <= '0;
      edges_q    <= '0;
      level_q    <= '0;
      spur_q     <= '0;
      latCnt_q   <= '0;
    end else begin
      if (state_q == IDLE && state_d == WR_MASK) maskPend_q <= cfg_mask;
      if (state_q == WR_MASK && cmdAccept)       shadow_q   <= maskPend_q;

      if (readAccept)             latCnt_q <= CNT_W'(1);
      else if (inWait && !latDone) latCnt_q <= latCnt_q + CNT_W'(1);

      if (state_q == WAIT_CAP && latDone) begin
        edges_q <= rdBits;
        if (rdZero) spur_q <= satInc(spur_q);
      end
      if (state_q == WAIT_DATA && latDone) level_q <= rdBits;
    end
  end

  always_comb begin
    bus.avm_chipselect = 1'b0;
    bus.avm_write_n    = 1'b1;
    bus.avm_address    = ADDR_DATA;
    bus.avm_writedata  = '0;
    bus.evt_valid      = 1'b0;
    bus.evt_edges      = '0;
    bus.evt_level      = '0;
    case (state_q)
      WR_MASK: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_write_n    = 1'b0;
        bus.avm_address    = ADDR_MASK;
        bus.avm_writedata  = AVM_DW'(maskPend_q);
      end
      RD_CAP: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_address    = ADDR_EDGE;
      end
      WR_CLR: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_write_n    = 1'b0;
        bus.avm_address    = ADDR_EDGE;
        bus.avm_writedata  = AVM_DW'(edges_q);
      end
      RD_DATA: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_address    = ADDR_DATA;
      end
      PUSH: begin
        bus.evt_valid = 1'b1;
        bus.evt_edges = edges_q;
        bus.evt_level = level_q;
      end
      default: ;
    endcase
  end

  assign spurious_cnt = spur_q;

endmodule

// File: tb/tb_pio_edge_master.sv
// Self-checking bench: a behavioural PIO slave logs bus traffic, a scenario model predicts it.
module tb_pio_edge_master;

  localparam int DATA_W = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic        cfg_enable;
  logic [9:0]  cfg_mask;
  logic [7:0]  spurious_cnt;

  pio_edge_master_if #(.DATA_W(DATA_W)) bus ();

  pio_edge_master #(.DATA_W(DATA_W), .READ_LATENCY(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .cfg_enable   (cfg_enable),
    .cfg_mask     (cfg_mask),
    .spurious_cnt (spurious_cnt),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checkCount = 0;
  int errCount   = 0;

  // Slave-side knobs owned by the main sequence.
  logic [9:0] capVal = '0;
  logic [9:0] dataVal = '0;
  int         servicesWanted = 0;
  int         stallCfg = 0;
  bit         stallRand = 1'b0;
  bit         readyRand = 1'b0;
  bit         readyForce = 1'b1;

  int         capReadsSeen = 0;
  assign irq = (capReadsSeen < servicesWanted);

  // Observed traffic: {write, address, data}, reads logged with data 0.
  logic [34:0] obsLog[$];
  int          obsCyc[$];
  logic [19:0] obsEvt[$];
  int          evtCyc[$];

  // Reference model state.
  logic [34:0] expLog[$];
  logic [19:0] expEvt[$];
  int          expSpur = 0;
  logic [9:0]  modelShadow = '0;
  int          logIdx = 0;
  int          evtIdx = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int nextStall();
    return stallRand ? int'($urandom_range(0, 3)) : stallCfg;
  endfunction

  // Behavioural slave: inserts stalls, answers reads one cycle after acceptance, junk otherwise.
  initial begin
    logic [31:0] junk;
    logic [34:0] cmd;
    logic [34:0] heldCmd;
    bit          inStall;
    bit          rdValid;
    logic [31:0] rdData;
    int          stallLeft;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    heldCmd = '0; inStall = 0; rdValid = 0; rdData = '0; stallLeft = 0;
    forever begin
      @(negedge clk);
      junk = $urandom;
      if (reset) begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = junk;
        rdValid = 0; inStall = 0; stallLeft = nextStall();
      end else begin
        bus.avm_readdata = rdValid ? rdData : junk;
        rdValid = 0;
        if (bus.avm_chipselect) begin
          cmd = {~bus.avm_write_n, bus.avm_address, bus.avm_writedata};
          if (inStall) checkOutput("cmd_stable", 64'(cmd), 64'(heldCmd));
          else         heldCmd = cmd;
          if (stallLeft > 0) begin
            bus.avm_waitrequest = 1'b1;
            stallLeft--;
            inStall = 1;
          end else begin
            bus.avm_waitrequest = 1'b0;
            inStall = 0;
            stallLeft = nextStall();
            obsLog.push_back(bus.avm_write_n ? {1'b0, bus.avm_address, 32'h0} : cmd);
            obsCyc.push_back(cycle);
            if (bus.avm_write_n) begin
              junk = $urandom;
              rdValid = 1;
              case (bus.avm_address)
                2'd3: begin
                  rdData = {junk[31:10], capVal};
                  capReadsSeen++;
                end
                2'd0:    rdData = {junk[31:10], dataVal};
                default: rdData = junk;
              endcase
            end
          end
        end else begin
          bus.avm_waitrequest = 1'b0;
          inStall = 0;
          stallLeft = nextStall();
        end
      end
    end
  end

  // Event monitor: logs handshakes and checks that a stalled event never moves or drops.
  initial begin
    bit          pend;
    logic [19:0] prevEvt;
    pend = 0; prevEvt = '0;
    forever begin
      @(negedge clk);
      if (reset) pend = 0;
      else begin
        if (pend) begin
          checkOutput("evt_valid_hold", 64'(bus.evt_valid), 64'd1);
          checkOutput("evt_payload_hold", 64'({bus.evt_edges, bus.evt_level}), 64'(prevEvt));
        end
        if (bus.evt_valid && bus.evt_ready) begin
          obsEvt.push_back({bus.evt_edges, bus.evt_level});
          evtCyc.push_back(cycle);
        end
        pend    = bus.evt_valid && !bus.evt_ready;
        prevEvt = {bus.evt_edges, bus.evt_level};
      end
    end
  end

  initial begin
    bus.evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.evt_ready = readyRand ? 1'($urandom_range(0, 1)) : readyForce;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cs"},     64'(bus.avm_chipselect), 64'd0);
    checkOutput({tag, "_wn"},     64'(bus.avm_write_n),    64'd1);
    checkOutput({tag, "_addr"},   64'(bus.avm_address),    64'd0);
    checkOutput({tag, "_wdata"},  64'(bus.avm_writedata),  64'd0);
    checkOutput({tag, "_valid"},  64'(bus.evt_valid),      64'd0);
    checkOutput({tag, "_edges"},  64'(bus.evt_edges),      64'd0);
    checkOutput({tag, "_level"},  64'(bus.evt_level),      64'd0);
    checkOutput({tag, "_spur"},   64'(spurious_cnt),       64'd0);
  endtask

  task automatic armService(input logic [9:0] c, input logic [9:0] d);
    capVal  = c;
    dataVal = d;
    servicesWanted++;
  endtask

  // One service as seen from outside: read capture; nothing found means a spurious count, else clear, read level, emit.
  task automatic modelService(input logic [9:0] c, input logic [9:0] d);
    expLog.push_back({1'b0, 2'd3, 32'h0});
    if (c == 10'h0) begin
      expSpur = (expSpur >= 255) ? 255 : expSpur + 1;
    end else begin
      expLog.push_back({1'b1, 2'd3, {22'h0, c}});
      expLog.push_back({1'b0, 2'd0, 32'h0});
      expEvt.push_back({c, d});
    end
  endtask

  task automatic applyStimulus(input logic [9:0] c, input logic [9:0] d, input logic [9:0] m);
    if (m != modelShadow) begin
      expLog.push_back({1'b1, 2'd2, {22'h0, m}});
      modelShadow = m;
    end
    cfg_mask = m;
    armService(c, d);
    modelService(c, d);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while ((obsLog.size() < expLog.size() || obsEvt.size() < expEvt.size()) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done"}, 64'(n < budget), 64'd1);
    tick(4);
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_bus_count"}, 64'(obsLog.size()), 64'(expLog.size()));
    for (int i = logIdx; i < obsLog.size() && i < expLog.size(); i++)
      checkOutput({tag, "_bus"}, 64'(obsLog[i]), 64'(expLog[i]));
    logIdx = (obsLog.size() < expLog.size()) ? obsLog.size() : expLog.size();
    checkOutput({tag, "_evt_count"}, 64'(obsEvt.size()), 64'(expEvt.size()));
    for (int i = evtIdx; i < obsEvt.size() && i < expEvt.size(); i++)
      checkOutput({tag, "_evt"}, 64'(obsEvt[i]), 64'(expEvt[i]));
    evtIdx = (obsEvt.size() < expEvt.size()) ? obsEvt.size() : expEvt.size();
    checkOutput({tag, "_spurious"}, 64'(spurious_cnt), 64'(expSpur));
  endtask

  initial begin
    int          n;
    int          base;
    int          evtBase;
    logic [31:0] r;
    logic [9:0]  c;
    logic [9:0]  m;

    reset      = 1'b0;
    cfg_enable = 1'b0;
    cfg_mask   = 10'h3FF;
    #2;
    reset = 1'b1;
    tick(3);
    checkResetOutputs("reset");

    // Mask differs from the cleared shadow, so a single mask write comes first.
    reset = 1'b0;
    expLog.push_back({1'b1, 2'd2, 32'h3FF});
    modelShadow = 10'h3FF;
    waitDone("init", 50);
    tick(20);
    compareAll("init");

    $display("[TB] basic service");
    cfg_enable = 1'b1;
    applyStimulus(10'h005, 10'h201, 10'h3FF);
    waitDone("basic", 100);
    compareAll("basic");

    $display("[TB] service with 3-cycle waitrequest");
    stallCfg = 3;
    applyStimulus(10'h005, 10'h201, 10'h3FF);
    waitDone("stall", 200);
    compareAll("stall");
    stallCfg = 0;

    $display("[TB] enable dropped mid-service");
    base = obsLog.size();
    applyStimulus(10'h0F0, 10'h155, 10'h3FF);
    n = 0;
    while (obsLog.size() <= base && n < 50) begin tick(); n++; end
    checkOutput("en_cap_read_seen", 64'(n < 50), 64'd1);
    cfg_enable = 1'b0;
    waitDone("en_mid", 100);
    compareAll("en_mid");
    base = obsLog.size();
    applyStimulus(10'h00C, 10'h0AA, 10'h3FF);
    tick(10);
    checkOutput("en_blocked", 64'(obsLog.size()), 64'(base));
    cfg_enable = 1'b1;
    waitDone("en_resume", 100);
    compareAll("en_resume");

    $display("[TB] irq still high after service");
    base    = obsLog.size();
    evtBase = obsEvt.size();
    applyStimulus(10'h111, 10'h222, 10'h3FF);
    applyStimulus(10'h111, 10'h222, 10'h3FF);
    waitDone("rearm", 200);
    compareAll("rearm");
    if (obsCyc.size() > base + 3 && evtCyc.size() > evtBase)
      checkOutput("rearm_gap", 64'(obsCyc[base+3] - evtCyc[evtBase]), 64'd2);
    else
      checkOutput("rearm_gap_missing", 64'd0, 64'd1);

    $display("[TB] event backpressure");
    readyForce = 1'b0;
    applyStimulus(10'h3C0, 10'h0FF, 10'h3FF);
    n = 0;
    while (!bus.evt_valid && n < 50) begin tick(); n++; end
    checkOutput("bp_push_reached", 64'(bus.evt_valid), 64'd1);
    base = obsLog.size();
    applyStimulus(10'h021, 10'h3AB, 10'h3FF);
    repeat (10) begin
      tick();
      checkOutput("bp_valid_held", 64'(bus.evt_valid), 64'd1);
    end
    checkOutput("bp_no_bus", 64'(obsLog.size()), 64'(base));
    readyForce = 1'b1;
    waitDone("bp", 200);
    compareAll("bp");

    $display("[TB] spurious interrupts");
    r = $urandom;
    applyStimulus(10'h000, r[9:0], 10'h3FF);
    waitDone("spur1", 50);
    compareAll("spur1");
    for (int i = 1; i < 256; i++) begin
      r = $urandom;
      applyStimulus(10'h000, r[9:0], 10'h3FF);
      waitDone("spur_loop", 50);
    end
    compareAll("spur256");

    $display("[TB] reset during WAIT_DATA");
    armService(10'h2A5, 10'h0C3);
    expLog.push_back({1'b0, 2'd3, 32'h0});
    expLog.push_back({1'b1, 2'd3, 32'h2A5});
    expLog.push_back({1'b0, 2'd0, 32'h0});
    n = 0;
    while (obsLog.size() < expLog.size() && n < 100) begin tick(); n++; end
    checkOutput("rstmid_reached", 64'(n < 100), 64'd1);
    reset = 1'b1;
    #1;
    checkResetOutputs("rstmid");
    tick();
    checkResetOutputs("rstmid_next");
    expSpur     = 0;
    modelShadow = 10'h0;
    tick(2);
    reset = 1'b0;
    expLog.push_back({1'b1, 2'd2, {22'h0, cfg_mask}});
    modelShadow = cfg_mask;
    waitDone("rstmid", 100);
    tick(5);
    compareAll("rstmid");

    $display("[TB] randomized services");
    stallRand = 1'b1;
    readyRand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      c = ($urandom_range(0, 3) == 0) ? 10'h000 : r[9:0];
      r = $urandom;
      m = ($urandom_range(0, 4) == 0) ? r[19:10] : modelShadow;
      applyStimulus(c, r[9:0], m);
      waitDone("rand", 400);
      compareAll("rand");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
